// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and default sizes for the mem_ctrl RAM initiator.
//   DATA_W_DEF / ADDR_W_DEF : default RAM word width / word-address width
//   state_t                 : transaction FSM states
//   gnt_t                   : which requester owns the current transaction
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_ctrl_arb.sv
// -----------------------------------------------------------------------------
// mem_ctrl_arb
// Combinational fixed-priority arbiter (data port beats fetch port) plus the
// mux that presents the winner's address / write data / write enable.
//   i_if_req, i_if_addr                  : fetch request (read-only)
//   i_d_req, i_d_we, i_d_addr, i_d_wdata : load/store request
//   o_any                                : some request is pending
//   o_gnt                                : winning port
//   o_addr, o_wdata, o_we                : winner's access fields
// -----------------------------------------------------------------------------
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_any,
    output gnt_t              o_gnt,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_we
);

    always_comb begin
        o_any = i_if_req | i_d_req;
        if (i_d_req) begin
            o_gnt   = GNT_D;
            o_addr  = i_d_addr;
            o_wdata = i_d_wdata;
            o_we    = i_d_we;
        end else begin
            // Fetches never write; write data is don't-care and held at zero.
            o_gnt   = GNT_IF;
            o_addr  = i_if_addr;
            o_wdata = '0;
            o_we    = 1'b0;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// CPU-side initiator for a single-port synchronous block RAM. Arbitrates a
// fetch port and a load/store port, drives registered RAM address/data/wren,
// absorbs the 1-cycle RAM read latency and returns a one-cycle ack per request.
//   clk, rst_n                              : clock, async active-low reset
//   if_req/if_addr -> if_ack/if_rdata       : fetch port
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata : data port
//   ram_address/ram_data/ram_wren, ram_q    : RAM interface
// Build option: define MEM_CTRL_FWD_EN to add a last-store forwarding buffer
// that serves matching reads in IDLE without touching the RAM.
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            r_state;
    gnt_t              r_gnt;
    logic              r_we;

    logic              w_any;
    gnt_t              w_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;

    mem_ctrl_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_arb (
        .i_if_req  (if_req),
        .i_if_addr (if_addr),
        .i_d_req   (d_req),
        .i_d_we    (d_we),
        .i_d_addr  (d_addr),
        .i_d_wdata (d_wdata),
        .o_any     (w_any),
        .o_gnt     (w_gnt),
        .o_addr    (w_addr),
        .o_wdata   (w_wdata),
        .o_we      (w_we)
    );

`ifdef MEM_CTRL_FWD_EN
    logic              r_fwd_vld;
    logic [ADDR_W-1:0] r_fwd_addr;
    logic [DATA_W-1:0] r_fwd_data;
    logic              w_fwd_hit;

    // A read (either port) hitting the last completed store skips the RAM.
    assign w_fwd_hit = w_any && !w_we && r_fwd_vld && (w_addr == r_fwd_addr);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= GNT_IF;
            r_we        <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            if_ack      <= 1'b0;
            if_rdata    <= '0;
            d_ack       <= 1'b0;
            d_rdata     <= '0;
`ifdef MEM_CTRL_FWD_EN
            r_fwd_vld   <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        // Grant and we are latched here; later request changes are ignored.
                        r_gnt <= w_gnt;
                        r_we  <= w_we;
`ifdef MEM_CTRL_FWD_EN
                        if (w_fwd_hit) begin
                            if (w_gnt == GNT_D) begin
                                d_rdata <= r_fwd_data;
                                d_ack   <= 1'b1;
                            end else begin
                                if_rdata <= r_fwd_data;
                                if_ack   <= 1'b1;
                            end
                            r_state <= ACK;
                        end else
`endif
                        begin
                            ram_address <= w_addr;
                            ram_data    <= w_wdata;
                            ram_wren    <= w_we;
                            r_state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // RAM samples address/wren at the edge closing this cycle.
                    ram_wren <= 1'b0;
                    r_state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (r_gnt == GNT_D) begin
                        if (!r_we) d_rdata <= ram_q;
                        d_ack <= 1'b1;
                    end else begin
                        if_rdata <= ram_q;
                        if_ack   <= 1'b1;
                    end
`ifdef MEM_CTRL_FWD_EN
                    if (r_we) begin
                        r_fwd_vld  <= 1'b1;
                        r_fwd_addr <= ram_address;
                        r_fwd_data <= ram_data;
                    end
`endif
                    r_state <= ACK;
                end
                ACK: begin
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 12;
`ifdef MEM_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    always #5 clk = ~clk;

    mem_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    // Single-port synchronous RAM model: q holds on write cycles.
    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        else          ram_q <= mem[ram_address];
    end

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Scoreboard: expected rdata per port, popped when that port acks.
    logic [DW-1:0] q_if[$];
    logic [DW-1:0] q_d[$];
    logic [DW-1:0] m_if = '0, m_d = '0;
    bit            f_vld = 1'b0;
    logic [AW-1:0] f_addr = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (if_ack) begin
                if (q_if.size() == 0) chk("if_spurious_ack", 1, 0);
                else chk("if_rdata", if_rdata, q_if.pop_front());
            end
            if (d_ack) begin
                if (q_d.size() == 0) chk("d_spurious_ack", 1, 0);
                else chk("d_rdata", d_rdata, q_d.pop_front());
            end
        end
    end

    task automatic run_txn(input bit pd, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                           input string nm);
        int lat = 0, wcnt = 0;
        bit done = 0, fwd;
        logic [AW-1:0] a1 = '0;
        fwd = FWD && !we && f_vld && (f_addr == addr);
        if (pd) begin
            if (we) q_d.push_back(m_d);
            else begin q_d.push_back(exp_rd); m_d = exp_rd; end
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            q_if.push_back(exp_rd); m_if = exp_rd;
            if_req = 1'b1; if_addr = addr;
        end
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ram_wren) wcnt++;
            if (lat == 1) a1 = ram_address;
            if (pd ? d_ack : if_ack) done = 1;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: no ack after %0d cycles", nm, lat);
        end
        chk({nm, "_latency"}, lat, fwd ? 1 : 3);
        chk({nm, "_wren_cycles"}, wcnt, (pd && we) ? 1 : 0);
        if (!fwd) chk({nm, "_ram_address"}, a1, addr);
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b0;
        if (pd && we) begin f_vld = 1'b1; f_addr = addr; end
    endtask

    typedef struct {
        bit            pd;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
        string         nm;
    } vec_t;
    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cd, ci, k, ak[2];
        for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
        #1;
        mem[12'h000] <= 16'h8002;
        mem[12'h001] <= 16'hC0DE;
        mem[12'h005] <= 16'h0505;
        mem[12'h006] <= 16'h0606;
        mem[12'h010] <= 16'h1234;
        mem[12'hFFF] <= 16'h7FFE;

        tbl[0] = '{0, 0, 12'h000, 16'h0000, 16'h8002, "fetch0"};
        tbl[1] = '{1, 1, 12'h020, 16'hBEEF, 16'h0000, "store20"};
        tbl[2] = '{1, 0, 12'h020, 16'h0000, 16'hBEEF, "load20"};
        tbl[3] = '{0, 0, 12'h020, 16'h0000, 16'hBEEF, "fetch20"};
        tbl[4] = '{1, 0, 12'hFFF, 16'h0000, 16'h7FFE, "loadFFF"};
        tbl[5] = '{1, 0, 12'h000, 16'h0000, 16'h8002, "load000"};
        tbl[6] = '{1, 1, 12'h030, 16'h1111, 16'h0000, "store30"};
        tbl[7] = '{1, 0, 12'h020, 16'h0000, 16'hBEEF, "load20b"};
        tbl[8] = '{0, 0, 12'h030, 16'h0000, 16'h1111, "fetch30"};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {if_ack, if_rdata, d_ack, d_rdata, ram_address, ram_data, ram_wren}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_txn(tbl[i].pd, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd, tbl[i].nm);

        // Simultaneous requests: data wins, fetch served in the next IDLE.
        q_d.push_back(16'h7FFE);
        q_if.push_back(16'hC0DE);
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'hFFF;
        if_req = 1'b1; if_addr = 12'h001;
        cd = -1; ci = -1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (d_ack && cd < 0) cd = n;
            if (if_ack && ci < 0) ci = n;
            if (n == 3) chk("sim_if_rdata_held", if_rdata, m_if);
            if (n == 4) d_req = 1'b0;
            if (n == 8) if_req = 1'b0;
        end
        chk("sim_d_ack_cycle", cd, 3);
        chk("sim_if_ack_cycle", ci, 7);
        m_d = 16'h7FFE; m_if = 16'hC0DE;

        // Back-to-back: req held through ack, address moved after ack.
        q_d.push_back(16'h0505);
        q_d.push_back(16'h0606);
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h005;
        k = 0; ak[0] = -1; ak[1] = -1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (d_ack) begin
                if (k < 2) ak[k] = n;
                k++;
            end
            if (n == 4) d_addr = 12'h006;
            if (n == 8) d_req = 1'b0;
        end
        chk("b2b_ack_count", k, 2);
        chk("b2b_ack0_cycle", ak[0], 3);
        chk("b2b_ack1_cycle", ak[1], 7);
        m_d = 16'h0606;

        // Reset during ACCESS of a store: write must be dropped.
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h010; d_wdata = 16'hABCD;
        @(posedge clk); #1;
        chk("rst_wren_in_access", ram_wren, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_immediate", {if_ack, if_rdata, d_ack, d_rdata, ram_address, ram_data, ram_wren}, 64'd0);
        d_req = 1'b0; d_we = 1'b0;
        m_d = '0; m_if = '0; f_vld = 1'b0;
        q_d.delete(); q_if.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_untouched", mem[12'h010], 16'h1234);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1, 0, 12'h010, 16'h0000, 16'h1234, "rst_load10");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_if_drained", q_if.size(), 0);
        chk("sb_d_drained", q_d.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
